// File: rtl/async_req_arbiter.sv
// async_req_arbiter: merges N asynchronous 4-phase req/ack requesters onto one
// clocked resource. Each req is brought into clk through a two-flop synchroniser;
// a round-robin FSM grants one requester at a time and closes the handshake once
// the resource reports done.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no grant outstanding; arbitrate among req_s & ~ack
// GRANT   | resource owned by grant_idx; waiting for done
// RELEASE | ack[grant_idx] high; waiting for the requester to drop its req
module async_req_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    ack,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic [N-1:0]    grant_onehot,
    input  logic            done,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    req_m_q;
    logic [N-1:0]    req_s_q;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            gv_q, gv_d;
    logic [IDXW-1:0] gidx_q, gidx_d;
    logic [N-1:0]    goh_q, goh_d;

    logic [N-1:0]    eligible;
    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [IDXW-1:0] cand;

    // Two-flop synchroniser; nothing between the stages so the first flop can settle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_m_q <= '0;
            req_s_q <= '0;
        end else begin
            req_m_q <= req;
            req_s_q <= req_m_q;
        end
    end

    // Requesters still holding an ack have not finished their handshake and are skipped.
    assign eligible = req_s_q & ~ack_q;

    // Round-robin pick: first eligible bit scanning upward from ptr, wrapping at N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDXW'((int'(ptr_q) + k) % N);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            ack_q   <= '0;
            gv_q    <= 1'b0;
            gidx_q  <= '0;
            goh_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            gv_q    <= gv_d;
            gidx_q  <= gidx_d;
            goh_q   <= goh_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a transition fires.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ack_d   = ack_q;
        gv_d    = gv_q;
        gidx_d  = gidx_q;
        goh_d   = goh_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gv_d           = 1'b1;
                    gidx_d         = win_idx;
                    goh_d          = '0;
                    goh_d[win_idx] = 1'b1;
                    state_d        = GRANT;
                end
            end
            GRANT: begin
                // A req dropped early is a protocol violation; the grant is still held until done.
                if (done) begin
                    gv_d          = 1'b0;
                    goh_d         = '0;
                    ack_d         = '0;
                    ack_d[gidx_q] = 1'b1;
                    state_d       = RELEASE;
                end
            end
            RELEASE: begin
                if (!req_s_q[gidx_q]) begin
                    ack_d   = '0;
                    // Just-serviced requester drops to lowest priority.
                    ptr_d   = (gidx_q == IDXW'(N - 1)) ? '0 : gidx_q + IDXW'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = '0;
                gv_d    = 1'b0;
                goh_d   = '0;
            end
        endcase
    end

    assign ack          = ack_q;
    assign grant_valid  = gv_q;
    assign grant_idx    = gidx_q;
    assign grant_onehot = goh_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_async_req_arbiter.sv
// Bench for async_req_arbiter: scoreboard of expected grant indices, popped
// whenever grant_valid rises; handshake latencies checked by the requester tasks.
module tb_async_req_arbiter;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N-1:0]    ack;
    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;
    logic [N-1:0]    grant_onehot;
    logic            done;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    logic gv_prev = 1'b0;

    async_req_arbiter #(.N(N), .IDXW(IDXW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .ack          (ack),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .done         (done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: every new grant must match the next queued index.
    always @(negedge clk) begin
        if (reset_n) begin
            check("ack_atmost1", 32'($countones(ack) <= 1), 1);
            if (grant_valid && !gv_prev) begin
                if (exp_q.size() == 0) begin
                    check("grant_unexpected", exp_q.size(), 1);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("grant_idx", 32'(grant_idx), e);
                    check("grant_onehot", 32'(grant_onehot), 32'(1) << e);
                end
            end
            if (!grant_valid) check("onehot_zero", 32'(grant_onehot), 0);
        end
        gv_prev = grant_valid;
    end

    task automatic wait_grant(output int lat);
        lat = 0;
        while (!grant_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("grant_timeout", 32'(grant_valid), 1);
    endtask

    // Hold the grant dly cycles, then pulse done for exactly one rising edge.
    task automatic serve(input int idx, input int dly);
        int lat;
        wait_grant(lat);
        repeat (dly) @(negedge clk);
        check("grant_hold", 32'(grant_idx), idx);
        check("grant_hold_gv", 32'(grant_valid), 1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("ack_set", 32'(ack), 32'(1) << idx);
        check("gv_drop", 32'(grant_valid), 0);
        check("busy_release", 32'(busy), 1);
    endtask

    // Drop req and expect ack low after the third rising edge.
    task automatic release_req(input int idx);
        int n;
        req[idx] = 1'b0;
        n = 0;
        while (ack[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ack_drop_lat", n, 3);
        check("busy_idle", 32'(busy), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_gv", 32'(grant_valid), 0);
        check("rst_idx", 32'(grant_idx), 0);
        check("rst_onehot", 32'(grant_onehot), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        do_reset();

        // Single request on 2; latency 3 edges to grant. Leaves ptr=3.
        exp_q.push_back(2);
        req[2] = 1'b1;
        wait_grant(lat);
        check("t1_grant_lat", lat, 3);
        check("t1_busy", 32'(busy), 1);
        serve(2, 5);
        release_req(2);

        // Fairness with wrap: ptr=3, requesters 3 and 0 keep re-raising.
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(3);
        exp_q.push_back(0);
        req[3] = 1'b1;
        req[0] = 1'b1;
        serve(3, 1);
        release_req(3);
        req[3] = 1'b1;
        serve(0, 2);
        release_req(0);
        req[0] = 1'b1;
        serve(3, 1);
        release_req(3);
        serve(0, 1);
        release_req(0);
        // ptr now 1

        // Spurious done in IDLE.
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (2) @(negedge clk);
        check("sp_idle_gv", 32'(grant_valid), 0);
        check("sp_idle_ack", 32'(ack), 0);
        check("sp_idle_busy", 32'(busy), 0);

        // Spurious done in RELEASE.
        exp_q.push_back(1);
        req[1] = 1'b1;
        serve(1, 1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (2) @(negedge clk);
        check("sp_rel_ack", 32'(ack), 4'b0010);
        check("sp_rel_gv", 32'(grant_valid), 0);
        check("sp_rel_busy", 32'(busy), 1);
        release_req(1);
        // ptr now 2

        // Reset mid-GRANT with grant_idx=1: outputs clear before any clock edge.
        exp_q.push_back(1);
        req[1] = 1'b1;
        wait_grant(lat);
        check("mr_idx", 32'(grant_idx), 1);
        #2;
        reset_n = 1'b0;
        req[1]  = 1'b0;
        #1;
        check("mr_ack", 32'(ack), 0);
        check("mr_gv", 32'(grant_valid), 0);
        check("mr_idx0", 32'(grant_idx), 0);
        check("mr_onehot", 32'(grant_onehot), 0);
        check("mr_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(1);
        req[1] = 1'b1;
        wait_grant(lat);
        check("mr_regrant_lat", lat, 3);
        serve(1, 0);
        release_req(1);

        // Simultaneous requests from reset (ptr=0): order 0, 1, 3.
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        req = 4'b1011;
        serve(0, 1);
        release_req(0);
        serve(1, 1);
        release_req(1);
        serve(3, 1);
        release_req(3);

        // Short pulse between two rising edges is never sampled.
        @(posedge clk);
        #2 req[0] = 1'b1;
        #5 req[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("gl_gv", 32'(grant_valid), 0);
            check("gl_ack", 32'(ack), 0);
            check("gl_busy", 32'(busy), 0);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/async_req_arbiter.md
Name: async_req_arbiter

Overview:
Merges N asynchronous 4-phase request/acknowledge requesters onto one shared synchronous resource in the clk domain. Each req input passes through an internal two-flop synchroniser. A round-robin FSM then grants the resource to one requester at a time. When the resource signals done, the block completes the 4-phase handshake back to the requester. It sits at the boundary between self-timed producers and the clocked datapath.

Parameters:
N, 4, number of requesters (2..16)
IDXW, 2, width of grant_idx; must equal ceil(log2(N))

Ports:
clk  input  1  clock
reset_n  input  1  reset; asynchronous, active-low
req  input  N  per-requester 4-phase request, asynchronous to clk
ack  output  N  per-requester 4-phase acknowledge, registered
grant_valid  output  1  resource currently granted, registered
grant_idx  output  IDXW  index of granted requester; valid only while grant_valid=1
grant_onehot  output  N  one-hot grant vector, registered; all zeros when grant_valid=0
done  input  1  single-cycle pulse from the resource: service for current grant complete
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync-release usage assumed by system): sync flops=0, ack=0, grant_valid=0, grant_idx=0, grant_onehot=0, busy=0, rr pointer=0, state=IDLE.
- Synchroniser: per bit, two flops on posedge clk, both reset to 0. req_s = second flop. No logic between the flops.
- FSM states:
  - IDLE: eligible = req_s & ~ack. If eligible is nonzero, pick the first set bit scanning from ptr upward, wrapping modulo N. At the next edge: grant_valid=1, grant_idx=winner, grant_onehot=1<<winner, state=GRANT. If eligible is zero, stay in IDLE.
  - GRANT: outputs held stable. On an edge with done=1: grant_valid=0, grant_onehot=0, ack[grant_idx]=1, state=RELEASE. grant_idx keeps its value.
  - RELEASE: on an edge where req_s[grant_idx]=0: ack[grant_idx]=0, ptr=(grant_idx+1) mod N, state=IDLE.
- busy=1 in GRANT and RELEASE; combinational from the state register.
- Latency:
  - Rising req meeting setup before edge E0: req_s=1 after edge E1, grant_valid=1 after edge E2.
  - done sampled at edge D: ack=1 and grant_valid=0 after edge D.
  - Falling req before edge F0: ack=0 after edge F1+1 (3rd edge).
  - Earliest next grant: one edge after the return to IDLE.
- At most one ack bit is high at any time. ack is never asserted without a preceding grant to that index.
- done outside GRANT is ignored, with no state change.
- If req_s[grant_idx] drops during GRANT (protocol violation), the grant is still held until done. RELEASE then completes in one cycle.
- Requests arriving during GRANT or RELEASE wait; they are arbitrated in the next IDLE cycle.
- Simultaneous requests are resolved purely by ptr order. A requester that just completed has lowest priority next round.
- ptr wraps from N-1 to 0.
- Reset mid-operation returns to the reset state immediately. A requester may then see its ack drop while req is still high; it must re-handshake.
- No combinational path from any input to any output.

Test Plan:
- Single request: req[2] rises, done pulsed 5 cycles after grant_valid. Required: grant_valid=1 with grant_idx=2 and grant_onehot=4'b0100 after the 3rd edge; ack[2]=1 the edge after done; req[2] falls; ack[2]=0 after 3 edges; busy returns to 0.
- Simultaneous requests: req=4'b1011 from reset (ptr=0), each serviced then released. Required: grant order 0, 1, 3.
- Fairness/wrap: req[3] and req[0] held continuously, re-raised after each release, with ptr starting at 3. Required: grants alternate 3, 0, 3, 0; ptr wraps to 0 after servicing 3.
- Spurious done: done pulsed in IDLE and in RELEASE. Required: no change on ack, grant_valid or state.
- Reset mid-GRANT: assert reset_n=0 asynchronously while grant_idx=1. Required: all outputs 0 immediately, without waiting for a clock edge; after release, a fresh req[1] is granted normally with ptr=0.
- Glitch/short pulse: req[0] pulse shorter than one clk period, aligned between edges. Required: no grant, no ack, FSM stays in IDLE. If the pulse is sampled by the synchroniser, the bench accepts exactly one full grant/ack cycle with ack dropping after req_s=0.
